// File: rtl/mem_wb_writeback_if.sv
// mem_wb_writeback_if: MEM-stage inputs, register-file write port and WB forwarding bundle.
// retire_count exists only when WB_RETIRE_CNT_EN is defined.
interface mem_wb_writeback_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               stall;
    logic               flush;
    logic               m_valid;
    logic               m_regwrite;
    logic [RADDR_W-1:0] m_rd;
    logic [1:0]         m_resultsrc;
    logic [2:0]         m_funct3;
    logic [XLEN-1:0]    m_alu_result;
    logic [XLEN-1:0]    m_read_data;
    logic [XLEN-1:0]    m_pc_plus4;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_a3;
    logic [XLEN-1:0]    rf_wd3;
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]    fwd_data;
    logic               retire_pulse;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]        retire_count;
`endif

    modport master (
        output stall, flush, m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3,
               m_alu_result, m_read_data, m_pc_plus4,
`ifdef WB_RETIRE_CNT_EN
        input  retire_count,
`endif
        input  rf_we, rf_a3, rf_wd3, fwd_valid, fwd_rd, fwd_data, retire_pulse
    );

    modport slave (
        input  stall, flush, m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3,
               m_alu_result, m_read_data, m_pc_plus4,
`ifdef WB_RETIRE_CNT_EN
        output retire_count,
`endif
        output rf_we, rf_a3, rf_wd3, fwd_valid, fwd_rd, fwd_data, retire_pulse
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: RV32I MEM/WB stage register, load extraction and register-file writeback.
// Define WB_RETIRE_CNT_EN to add the 64-bit retire_count output.
module mem_wb_writeback #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic               clk,
    input logic               reset,
    mem_wb_writeback_if.slave bus
);
    logic               r_valid;
    logic               r_done;
    logic               r_regwrite;
    logic [RADDR_W-1:0] r_rd;
    logic [1:0]         r_resultsrc;
    logic [2:0]         r_funct3;
    logic [XLEN-1:0]    r_alu;
    logic [XLEN-1:0]    r_rdata;
    logic [XLEN-1:0]    r_pc4;

    logic [1:0]         w_off;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_sext;
    logic [XLEN-1:0]    w_load;
    logic [XLEN-1:0]    w_result;
    logic               w_fwd;
    logic               w_retire;

    // done marks a held instruction whose write and retirement already happened
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_regwrite  <= 1'b0;
            r_rd        <= '0;
            r_resultsrc <= '0;
            r_funct3    <= '0;
            r_alu       <= '0;
            r_rdata     <= '0;
            r_pc4       <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.stall) begin
            r_done <= r_done | r_valid;
        end else begin
            r_valid     <= bus.m_valid;
            r_done      <= 1'b0;
            r_regwrite  <= bus.m_regwrite;
            r_rd        <= bus.m_rd;
            r_resultsrc <= bus.m_resultsrc;
            r_funct3    <= bus.m_funct3;
            r_alu       <= bus.m_alu_result;
            r_rdata     <= bus.m_read_data;
            r_pc4       <= bus.m_pc_plus4;
        end
    end

    // funct3[1] selects full word, funct3[0] halfword vs byte, funct3[2] zero-extension
    always_comb begin
        w_off    = r_alu[1:0];
        w_byte   = r_rdata[{w_off, 3'b000} +: 8];
        w_half   = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];
        w_sext   = !r_funct3[2] & (r_funct3[0] ? w_half[15] : w_byte[7]);
        w_load   = r_funct3[1] ? r_rdata :
                   r_funct3[0] ? {{16{w_sext}}, w_half} : {{24{w_sext}}, w_byte};
        w_result = (r_resultsrc == 2'b01) ? w_load :
                   (r_resultsrc == 2'b10) ? r_pc4 : r_alu;
        w_fwd    = r_valid & r_regwrite & (r_rd != '0);
        w_retire = r_valid & !r_done;
    end

    assign bus.rf_we        = w_fwd & !r_done;
    assign bus.rf_a3        = r_rd;
    assign bus.rf_wd3       = w_result;
    assign bus.fwd_valid    = w_fwd;
    assign bus.fwd_rd       = r_rd;
    assign bus.fwd_data     = w_result;
    assign bus.retire_pulse = w_retire;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retire_cnt <= '0;
        else if (w_retire)
            r_retire_cnt <= r_retire_cnt + 64'd1;
    end

    assign bus.retire_count = r_retire_cnt;
`endif
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed vector table plus stall/flush/reset sequences for mem_wb_writeback.
module tb_mem_wb_writeback;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_wb_writeback_if #(.XLEN(32), .RADDR_W(5)) bus ();

    mem_wb_writeback #(.XLEN(32), .RADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic        e_we;
        logic        e_fv;
        logic        e_rp;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4);
        bus.m_valid      = v;
        bus.m_regwrite   = rw;
        bus.m_rd         = rd;
        bus.m_resultsrc  = rs;
        bus.m_funct3     = f3;
        bus.m_alu_result = alu;
        bus.m_read_data  = rdata;
        bus.m_pc_plus4   = pc4;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic fv, input logic rp,
                           input logic [4:0] rd, input logic [31:0] wd);
        chk({tag, ".rf_we"}, 64'(bus.rf_we), 64'(we));
        chk({tag, ".fwd_valid"}, 64'(bus.fwd_valid), 64'(fv));
        chk({tag, ".retire"}, 64'(bus.retire_pulse), 64'(rp));
        chk({tag, ".rf_a3"}, 64'(bus.rf_a3), 64'(rd));
        chk({tag, ".fwd_rd"}, 64'(bus.fwd_rd), 64'(rd));
        chk({tag, ".rf_wd3"}, 64'(bus.rf_wd3), 64'(wd));
        chk({tag, ".fwd_data"}, 64'(bus.fwd_data), 64'(wd));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_0011, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 32'h0000_0011};
        vt[1]  = '{1'b1, 5'd6, 2'b01, 3'b000, 32'h0000_1000, 32'h8081_F0F7, 32'h8, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7};
        vt[2]  = '{1'b1, 5'd6, 2'b01, 3'b100, 32'h0000_1002, 32'h8081_F0F7, 32'h8, 1'b1, 1'b1, 1'b1, 32'h0000_0081};
        vt[3]  = '{1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_1002, 32'h8081_F0F7, 32'h8, 1'b1, 1'b1, 1'b1, 32'hFFFF_8081};
        vt[4]  = '{1'b1, 5'd6, 2'b01, 3'b101, 32'h0000_1003, 32'h8081_F0F7, 32'h8, 1'b1, 1'b1, 1'b1, 32'h0000_8081};
        vt[5]  = '{1'b1, 5'd6, 2'b01, 3'b010, 32'h0000_1001, 32'h8081_F0F7, 32'h8, 1'b1, 1'b1, 1'b1, 32'h8081_F0F7};
        vt[6]  = '{1'b1, 5'd0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h8, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[7]  = '{1'b1, 5'd7, 2'b11, 3'b000, 32'h0000_1234, 32'h5555_5555, 32'h8, 1'b1, 1'b1, 1'b1, 32'h0000_1234};
        vt[8]  = '{1'b0, 5'd9, 2'b00, 3'b010, 32'h0000_2000, 32'h0, 32'h8, 1'b0, 1'b0, 1'b1, 32'h0000_2000};
        vt[9]  = '{1'b1, 5'd10, 2'b01, 3'b000, 32'h0000_1001, 32'h8081_F0F7, 32'h8, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0};
        vt[10] = '{1'b1, 5'd11, 2'b01, 3'b001, 32'h0000_1001, 32'h8081_F0F7, 32'h8, 1'b1, 1'b1, 1'b1, 32'hFFFF_F0F7};
        vt[11] = '{1'b1, 5'd12, 2'b10, 3'b000, 32'h0000_7777, 32'h0, 32'h0000_0200, 1'b1, 1'b1, 1'b1, 32'h0000_0200};
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'hAAAA_AAAA, 32'h0, 32'h0);
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_out("reset_edge", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #3 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vt[i].rw, vt[i].rd, vt[i].rs, vt[i].f3, vt[i].alu, vt[i].rdata, vt[i].pc4);
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_fv, vt[i].e_rp, vt[i].rd, vt[i].e_wd);
        end
        drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0000_0500, 32'h0, 32'h0000_0104);
        tick();
        chk_out("jal_c0", 1'b1, 1'b1, 1'b1, 5'd1, 32'h0000_0104);
        bus.stall = 1'b1;
        drive(1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h9999_9999, 32'h0, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk_out($sformatf("jal_c%0d", c), 1'b0, 1'b1, 1'b0, 5'd1, 32'h0000_0104);
        end
        bus.flush = 1'b1;
        tick();
        chk("flush_held.rf_we", 64'(bus.rf_we), 64'd0);
        chk("flush_held.fwd_valid", 64'(bus.fwd_valid), 64'd0);
        chk("flush_held.retire", 64'(bus.retire_pulse), 64'd0);
        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h0000_0044, 32'h0, 32'h0);
        tick();
        chk("stall_flush.rf_we", 64'(bus.rf_we), 64'd0);
        chk("stall_flush.fwd_valid", 64'(bus.fwd_valid), 64'd0);
        chk("stall_flush.retire", 64'(bus.retire_pulse), 64'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_0033, 32'h0, 32'h0);
        tick();
        chk_out("pre_rst", 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0033);
        bus.stall = 1'b1;
        tick();
        chk_out("pre_rst_stall", 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0033);
        #2 reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        #2 reset = 1'b0;
        bus.stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("post_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
`ifdef WB_RETIRE_CNT_EN
        chk("cnt_reset", bus.retire_count, 64'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                bus.flush = 1'b1;
                drive(1'b1, 1'b1, 5'd20, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
                tick();
                bus.flush = 1'b0;
            end
            drive(1'b1, 1'b1, 5'(i), 2'b00, 3'b000, 32'(i), 32'h0, 32'h0);
            tick();
            if (i == 3 || i == 6) begin
                bus.stall = 1'b1;
                tick();
                tick();
                bus.stall = 1'b0;
            end
        end
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        chk("cnt_ten", bus.retire_count, 64'd10);
        force dut.r_retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        drive(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 32'h8, 32'h0, 32'h0);
        tick();
        chk("cnt_max", bus.retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        chk("cnt_wrap", bus.retire_count, 64'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
